// File: rtl/fetch_stage_pkg.sv
// Shared fetch/decode constants: opcode field position, two-word opcode,
// bubble instruction and the fetch FSM state encoding.
package fetch_stage_pkg;

  localparam int          OPC_MSB        = 15;
  localparam int          OPC_LSB        = 13;
  localparam logic [2:0]  IMM_OPCODE_DEF = 3'b110;
  localparam logic [15:0] NOP_INSTR_DEF  = 16'h0000;

  typedef enum logic {
    FETCH     = 1'b0,
    FETCH_IMM = 1'b1
  } fetch_state_e;

  function automatic logic [2:0] opcode_of(input logic [15:0] word);
    return word[OPC_MSB:OPC_LSB];
  endfunction

endpackage

// File: rtl/fetch_stage_instr_mem.sv
// Instruction memory: 2^ADDR_W x 16 array with combinational read.
module instr_mem #(
  parameter int    ADDR_W   = 10,
  parameter string MEM_FILE = "instr.mem"
) (
  input  logic [ADDR_W-1:0] addr,
  output logic [15:0]       rdata
);

  logic [15:0] mem [0:(1<<ADDR_W)-1];

  assign rdata = mem[addr];

endmodule

// File: rtl/fetch_stage.sv
// Fetch stage: PC, two-word instruction assembly FSM and the IF/ID register,
// with stall, flush and branch redirect.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter int          ADDR_W     = 10,
  parameter logic [15:0] RESET_PC   = 16'h0000,
  parameter logic [2:0]  IMM_OPCODE = IMM_OPCODE_DEF,
  parameter logic [15:0] NOP_INSTR  = NOP_INSTR_DEF,
  parameter string       MEM_FILE   = "instr.mem"
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        flush,
  input  logic        branch_taken,
  input  logic [15:0] branch_target,
  output logic [15:0] if_id_instruction,
  output logic [15:0] if_id_immediate,
  output logic [15:0] if_id_pc_plus,
  output logic        if_id_valid
);

  fetch_state_e state_q, state_d;
  logic [15:0]  pc_q, pc_d;
  logic [15:0]  hold_instr_q, hold_instr_d;
  logic [15:0]  instr_q, instr_d;
  logic [15:0]  imm_q, imm_d;
  logic [15:0]  pc_plus_q, pc_plus_d;
  logic         valid_q, valid_d;

  logic [15:0]  fetch_word;
  logic [15:0]  pc_plus_one;

  instr_mem #(
    .ADDR_W   (ADDR_W),
    .MEM_FILE (MEM_FILE)
  ) u_mem (
    .addr  (pc_q[ADDR_W-1:0]),
    .rdata (fetch_word)
  );

  assign pc_plus_one = pc_q + 16'd1;

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    hold_instr_d = hold_instr_q;
    instr_d      = instr_q;
    imm_d        = imm_q;
    pc_plus_d    = pc_plus_q;
    valid_d      = valid_q;

    if (branch_taken || flush) begin
      // A redirect outranks stall; plain flush refetches the current word.
      pc_d      = branch_taken ? branch_target : pc_q;
      state_d   = FETCH;
      instr_d   = NOP_INSTR;
      imm_d     = 16'h0000;
      pc_plus_d = 16'h0000;
      valid_d   = 1'b0;
    end else if (!stall) begin
      pc_d = pc_plus_one;
      case (state_q)
        FETCH: begin
          if (opcode_of(fetch_word) == IMM_OPCODE) begin
            hold_instr_d = fetch_word;
            state_d      = FETCH_IMM;
            instr_d      = NOP_INSTR;
            imm_d        = 16'h0000;
            pc_plus_d    = 16'h0000;
            valid_d      = 1'b0;
          end else begin
            instr_d   = fetch_word;
            imm_d     = 16'h0000;
            pc_plus_d = pc_plus_one;
            valid_d   = 1'b1;
          end
        end
        FETCH_IMM: begin
          instr_d   = hold_instr_q;
          imm_d     = fetch_word;
          pc_plus_d = pc_plus_one;
          valid_d   = 1'b1;
          state_d   = FETCH;
        end
        default: state_d = FETCH;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= FETCH;
      pc_q         <= RESET_PC;
      hold_instr_q <= 16'h0000;
      instr_q      <= NOP_INSTR;
      imm_q        <= 16'h0000;
      pc_plus_q    <= 16'h0000;
      valid_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      hold_instr_q <= hold_instr_d;
      instr_q      <= instr_d;
      imm_q        <= imm_d;
      pc_plus_q    <= pc_plus_d;
      valid_q      <= valid_d;
    end
  end

  assign if_id_instruction = instr_q;
  assign if_id_immediate   = imm_q;
  assign if_id_pc_plus     = pc_plus_q;
  assign if_id_valid       = valid_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: memory is preloaded per scenario and the
// IF/ID register is compared against hand-computed words after each edge.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic        flush = 1'b0;
  logic        branch_taken = 1'b0;
  logic [15:0] branch_target = 16'h0000;
  logic [15:0] if_id_instruction;
  logic [15:0] if_id_immediate;
  logic [15:0] if_id_pc_plus;
  logic        if_id_valid;

  int tests_run = 0;
  int tests_failed = 0;

  localparam logic [48:0] BUBBLE = 49'h0;

  // {instruction, immediate, pc_plus, valid}
  logic [48:0] obs;
  assign obs = {if_id_instruction, if_id_immediate, if_id_pc_plus, if_id_valid};

  always #5 clk = ~clk;

  fetch_stage #(
    .ADDR_W   (10),
    .RESET_PC (16'h0000),
    .MEM_FILE ("")
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .stall             (stall),
    .flush             (flush),
    .branch_taken      (branch_taken),
    .branch_target     (branch_target),
    .if_id_instruction (if_id_instruction),
    .if_id_immediate   (if_id_immediate),
    .if_id_pc_plus     (if_id_pc_plus),
    .if_id_valid       (if_id_valid)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 1024; i++) dut.u_mem.mem[i] = 16'h0000;
  endtask

  // One reset edge, then release; the next step shows the first fetch.
  task automatic start();
    stall = 1'b0; flush = 1'b0; branch_taken = 1'b0; branch_target = 16'h0000;
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset_run();
    logic [48:0] exp [3];
    clear_mem();
    dut.u_mem.mem[0] = 16'h2001;
    dut.u_mem.mem[1] = 16'h4002;
    dut.u_mem.mem[2] = 16'h0003;
    rst = 1'b1;
    step();
    step();
    tests_run++;
    if (obs !== BUBBLE) begin
      tests_failed++;
      $display("FAIL reset_state got %h expected %h", obs, BUBBLE);
    end
    rst = 1'b0;
    exp = '{{16'h2001, 16'h0000, 16'h0001, 1'b1},
            {16'h4002, 16'h0000, 16'h0002, 1'b1},
            {16'h0003, 16'h0000, 16'h0003, 1'b1}};
    for (int i = 0; i < 3; i++) begin
      step();
      tests_run++;
      if (obs !== exp[i]) begin
        tests_failed++;
        $display("FAIL run_seq[%0d] got %h expected %h", i, obs, exp[i]);
      end
    end
    $display("[TB] reset_run done");
  endtask

  task automatic test_two_word();
    logic [48:0] exp [3];
    clear_mem();
    dut.u_mem.mem[0] = 16'hC123;
    dut.u_mem.mem[1] = 16'hBEEF;
    dut.u_mem.mem[2] = 16'h2001;
    start();
    exp = '{BUBBLE,
            {16'hC123, 16'hBEEF, 16'h0002, 1'b1},
            {16'h2001, 16'h0000, 16'h0003, 1'b1}};
    for (int i = 0; i < 3; i++) begin
      step();
      tests_run++;
      if (obs !== exp[i]) begin
        tests_failed++;
        $display("FAIL two_word[%0d] got %h expected %h", i, obs, exp[i]);
      end
    end
    $display("[TB] two_word done");
  endtask

  task automatic test_stall_two_word();
    logic [48:0] c123 = {16'hC123, 16'hBEEF, 16'h0002, 1'b1};
    logic [48:0] nxt  = {16'h2001, 16'h0000, 16'h0003, 1'b1};
    clear_mem();
    dut.u_mem.mem[0] = 16'hC123;
    dut.u_mem.mem[1] = 16'hBEEF;
    dut.u_mem.mem[2] = 16'h2001;
    start();
    step();
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      tests_run++;
      if (obs !== BUBBLE) begin
        tests_failed++;
        $display("FAIL stall_imm[%0d] got %h expected %h", i, obs, BUBBLE);
      end
    end
    stall = 1'b0;
    step();
    tests_run++;
    if (obs !== c123) begin
      tests_failed++;
      $display("FAIL stall_release got %h expected %h", obs, c123);
    end
    stall = 1'b1;
    step();
    tests_run++;
    if (obs !== c123) begin
      tests_failed++;
      $display("FAIL stall_hold_valid got %h expected %h", obs, c123);
    end
    stall = 1'b0;
    step();
    tests_run++;
    if (obs !== nxt) begin
      tests_failed++;
      $display("FAIL stall_once got %h expected %h", obs, nxt);
    end
    $display("[TB] stall_two_word done");
  endtask

  task automatic test_branch();
    logic [48:0] exp [2];
    clear_mem();
    dut.u_mem.mem[0]  = 16'hC123;
    dut.u_mem.mem[1]  = 16'hBEEF;
    dut.u_mem.mem[16] = 16'h3456;
    dut.u_mem.mem[17] = 16'h1111;
    start();
    step();
    tests_run++;
    if (obs !== BUBBLE) begin
      tests_failed++;
      $display("FAIL branch_pre got %h expected %h", obs, BUBBLE);
    end
    branch_taken = 1'b1; branch_target = 16'h0010; stall = 1'b1;
    step();
    branch_taken = 1'b0; stall = 1'b0;
    tests_run++;
    if (obs !== BUBBLE) begin
      tests_failed++;
      $display("FAIL branch_bubble got %h expected %h", obs, BUBBLE);
    end
    exp = '{{16'h3456, 16'h0000, 16'h0011, 1'b1},
            {16'h1111, 16'h0000, 16'h0012, 1'b1}};
    for (int i = 0; i < 2; i++) begin
      step();
      tests_run++;
      if (obs !== exp[i]) begin
        tests_failed++;
        $display("FAIL branch_target[%0d] got %h expected %h", i, obs, exp[i]);
      end
    end
    $display("[TB] branch done");
  endtask

  task automatic test_flush_vs_stall();
    logic [48:0] first  = {16'h2001, 16'h0000, 16'h0001, 1'b1};
    logic [48:0] second = {16'h4002, 16'h0000, 16'h0002, 1'b1};
    clear_mem();
    dut.u_mem.mem[0] = 16'h2001;
    dut.u_mem.mem[1] = 16'h4002;
    start();
    step();
    tests_run++;
    if (obs !== first) begin
      tests_failed++;
      $display("FAIL flush_pre got %h expected %h", obs, first);
    end
    flush = 1'b1; stall = 1'b1;
    step();
    flush = 1'b0; stall = 1'b0;
    tests_run++;
    if (obs !== BUBBLE) begin
      tests_failed++;
      $display("FAIL flush_bubble got %h expected %h", obs, BUBBLE);
    end
    step();
    tests_run++;
    if (obs !== second) begin
      tests_failed++;
      $display("FAIL flush_refetch got %h expected %h", obs, second);
    end
    $display("[TB] flush_vs_stall done");
  endtask

  task automatic test_wrap_and_reset();
    logic [48:0] wrap  = {16'h5555, 16'h0000, 16'h0000, 1'b1};
    logic [48:0] after = {16'h2001, 16'h0000, 16'h0001, 1'b1};
    clear_mem();
    dut.u_mem.mem[1023] = 16'h5555;
    dut.u_mem.mem[0]    = 16'h2001;
    dut.u_mem.mem[1]    = 16'hC123;
    dut.u_mem.mem[2]    = 16'hBEEF;
    start();
    branch_taken = 1'b1; branch_target = 16'hFFFF;
    step();
    branch_taken = 1'b0;
    step();
    tests_run++;
    if (obs !== wrap) begin
      tests_failed++;
      $display("FAIL wrap_pc_plus got %h expected %h", obs, wrap);
    end
    step();
    tests_run++;
    if (obs !== after) begin
      tests_failed++;
      $display("FAIL wrap_next got %h expected %h", obs, after);
    end
    step();
    tests_run++;
    if (obs !== BUBBLE) begin
      tests_failed++;
      $display("FAIL imm_first got %h expected %h", obs, BUBBLE);
    end
    rst = 1'b1;
    step();
    tests_run++;
    if (obs !== BUBBLE) begin
      tests_failed++;
      $display("FAIL reset_in_imm got %h expected %h", obs, BUBBLE);
    end
    rst = 1'b0;
    step();
    tests_run++;
    if (obs !== after) begin
      tests_failed++;
      $display("FAIL reset_pc got %h expected %h", obs, after);
    end
    $display("[TB] wrap_and_reset done");
  endtask

  initial begin
    #1;
    test_reset_run();
    test_two_word();
    test_stall_two_word();
    test_branch();
    test_flush_vs_stall();
    test_wrap_and_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
